image_stream_rx_ctrl: RTL and testbench

Parametrised UART-to-memory image receive controller. Waits for a sync byte, receives an image of `IMAGE_BUF_X × IMAGE_BUF_Y` pixels of `BYTES_PER_PIXEL` bytes each, and writes every byte to memory through a request/ready handshake. It returns an ACK byte once per `ACK_WINDOW` bytes and after the final byte. The block sits between the UART rx/tx pair and the frame-buffer memory port.

---
 rtl/image_stream_pkg.sv | 17 +
 rtl/stream_byte_sender.sv | 30 +++
 rtl/image_stream_rx_ctrl.sv | 155 +++++++++++++++
 tb/tb_image_stream_rx_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_pkg.sv
// rtl/image_stream_pkg.sv - shared protocol bytes and state encoding for the image stream receiver
package image_stream_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hAA;
    localparam logic [7:0] ACK_BYTE  = 8'hAA;
    localparam logic [7:0] NAK_BYTE  = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_STORE = 3'd2,
        S_ACK   = 3'd3,
        S_CHECK = 3'd4,
        S_END   = 3'd5
    } state_t;

endpackage

// File: rtl/stream_byte_sender.sv
// rtl/stream_byte_sender.sv - one-byte request/busy handshake towards a UART transmitter
module stream_byte_sender (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] byte_data,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done
);

    // done is combinational so the owner can leave its state on the accepting edge
    assign done = tx_ready && tx_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_data  <= 8'h00;
            tx_ready <= 1'b0;
        end else begin
            if (start && !tx_busy && !tx_ready) begin
                tx_data  <= byte_data;
                tx_ready <= 1'b1;
            end else if (tx_ready && tx_busy) begin
                tx_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/image_stream_rx_ctrl.sv
// rtl/image_stream_rx_ctrl.sv - UART-to-memory image receiver; IMAGE_STREAM_CHECKSUM_EN adds an XOR checksum check
module image_stream_rx_ctrl
    import image_stream_pkg::*;
#(
    parameter int          IMAGE_BUF_X     = 1,
    parameter int          IMAGE_BUF_Y     = 1,
    parameter int          BYTES_PER_PIXEL = 2,
    parameter int          ACK_WINDOW      = 1,
    parameter logic [31:0] BASE_ADDR       = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    input  logic        tx_busy,
    input  logic        mem_ready,
    output logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        mem_req,
    output logic [7:0]  mem_in,
    output logic [31:0] mem_addr,
    output logic        streaming_ended,
    output logic        rx_overrun,
    output logic        busy
);

    localparam int TOTAL = IMAGE_BUF_X * IMAGE_BUF_Y * BYTES_PER_PIXEL;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int WW    = $clog2(ACK_WINDOW + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [WW-1:0] win;
    logic          frame_done;
    logic [7:0]    ack_byte;
    logic          send_done;
    logic [31:0]   cnt_inc;
    logic [31:0]   win_inc;

`ifdef IMAGE_STREAM_CHECKSUM_EN
    logic [7:0]    csum;
    logic          csum_ok;
`else
    assign ack_byte = ACK_BYTE;
`endif

    assign cnt_inc  = 32'(cnt) + 32'd1;
    assign win_inc  = 32'(win) + 32'd1;
    assign mem_addr = BASE_ADDR + 32'(cnt);
    assign busy     = (state != S_IDLE);

    stream_byte_sender u_sender (
        .clk       (clk),
        .reset     (reset),
        .start     (state == S_ACK),
        .byte_data (ack_byte),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .done      (send_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            win             <= '0;
            frame_done      <= 1'b0;
            mem_req         <= 1'b0;
            mem_in          <= 8'h00;
            streaming_ended <= 1'b0;
            rx_overrun      <= 1'b0;
`ifdef IMAGE_STREAM_CHECKSUM_EN
            csum            <= 8'h00;
            csum_ok         <= 1'b0;
            ack_byte        <= ACK_BYTE;
`endif
        end else begin
            streaming_ended <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rx_ready && rx_data == SYNC_BYTE) begin
                        cnt        <= '0;
                        win        <= '0;
                        frame_done <= 1'b0;
                        rx_overrun <= 1'b0;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                        csum       <= 8'h00;
                        csum_ok    <= 1'b0;
                        ack_byte   <= ACK_BYTE;
`endif
                        state      <= S_RECV;
                    end
                end
                S_RECV: begin
                    // a SYNC value here is ordinary pixel data
                    if (rx_ready) begin
                        mem_in <= rx_data;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                        csum   <= csum ^ rx_data;
`endif
                        state  <= S_STORE;
                    end
                end
                S_STORE: begin
                    if (rx_ready) rx_overrun <= 1'b1;
                    if (!mem_ready && !mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_req && mem_ready) begin
                        mem_req <= 1'b0;
                        cnt     <= cnt + 1'b1;
                        win     <= win + 1'b1;
                        if (cnt_inc == 32'(TOTAL)) begin
                            frame_done <= 1'b1;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                            state      <= S_CHECK;
`else
                            state      <= S_ACK;
`endif
                        end else if (win_inc == 32'(ACK_WINDOW)) begin
                            win   <= '0;
                            state <= S_ACK;
                        end else begin
                            state <= S_RECV;
                        end
                    end
                end
`ifdef IMAGE_STREAM_CHECKSUM_EN
                S_CHECK: begin
                    if (rx_ready) begin
                        csum_ok  <= (rx_data == csum);
                        ack_byte <= (rx_data == csum) ? ACK_BYTE : NAK_BYTE;
                        state    <= S_ACK;
                    end
                end
`endif
                S_ACK: begin
                    if (rx_ready) rx_overrun <= 1'b1;
                    if (send_done) state <= frame_done ? S_END : S_RECV;
                end
                S_END: begin
                    if (rx_ready) rx_overrun <= 1'b1;
`ifdef IMAGE_STREAM_CHECKSUM_EN
                    streaming_ended <= csum_ok;
`else
                    streaming_ended <= 1'b1;
`endif
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_rx_ctrl.sv
// tb/tb_image_stream_rx_ctrl.sv - scoreboard bench for image_stream_rx_ctrl (10-byte frames, window 4, wrapping base)
module tb_image_stream_rx_ctrl;

    localparam int          X     = 5;
    localparam int          Y     = 1;
    localparam int          BPP   = 2;
    localparam int          WIN   = 4;
    localparam int          TOTAL = X * Y * BPP;
    localparam logic [31:0] BASE  = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        tx_busy;
    logic        mem_ready;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        mem_req;
    logic [7:0]  mem_in;
    logic [31:0] mem_addr;
    logic        streaming_ended;
    logic        rx_overrun;
    logic        busy;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    bit         exp_end[$];
    int n_cmp = 0;
    int n_bad = 0;
    int wr_seen = 0;
    int tx_seen = 0;
    int stall_left = 0;

    image_stream_rx_ctrl #(
        .IMAGE_BUF_X(X), .IMAGE_BUF_Y(Y), .BYTES_PER_PIXEL(BPP),
        .ACK_WINDOW(WIN), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_busy(tx_busy), .mem_ready(mem_ready), .tx_data(tx_data),
        .tx_ready(tx_ready), .mem_req(mem_req), .mem_in(mem_in),
        .mem_addr(mem_addr), .streaming_ended(streaming_ended),
        .rx_overrun(rx_overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // memory responder: ready one cycle after request unless a stall is armed
    always @(posedge clk) begin
        #1;
        if (mem_req && !mem_ready) begin
            if (stall_left > 0) stall_left--;
            else mem_ready = 1'b1;
        end else if (!mem_req) begin
            mem_ready = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (tx_ready && !tx_busy) tx_busy = 1'b1;
        else if (!tx_ready) tx_busy = 1'b0;
    end

    // monitor: pops expectations whenever the DUT completes a handshake
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ready) begin
                wr_seen++;
                if (exp_wr.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", mem_addr, mem_in);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check32("write_addr", mem_addr, e.addr);
                    check32("write_data", {24'd0, mem_in}, {24'd0, e.data});
                end
            end
            if (tx_ready && tx_busy) begin
                tx_seen++;
                if (exp_tx.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_tx: got %h expected none", tx_data);
                end else begin
                    logic [7:0] t;
                    t = exp_tx.pop_front();
                    check32("tx_byte", {24'd0, tx_data}, {24'd0, t});
                end
            end
            if (streaming_ended) begin
                n_cmp++;
                if (exp_end.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_end_pulse: got 1 expected 0");
                end else begin
                    void'(exp_end.pop_front());
                end
            end
        end
    end

    task automatic drive_rx(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(posedge clk); #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_wr(input int target);
        int t = 0;
        while (wr_seen < target && t < 300) begin @(posedge clk); t++; end
        #1;
        check32("write_seen", wr_seen, target);
    endtask

    task automatic wait_tx(input int target);
        int t = 0;
        while (tx_seen < target && t < 300) begin @(posedge clk); t++; end
        #1;
        check32("tx_seen", tx_seen, target);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 300) begin @(posedge clk); #1; t++; end
        check32("busy_fall", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_vals();
        check32("rst_tx_data", {24'd0, tx_data}, 32'h00);
        check32("rst_tx_ready", {31'd0, tx_ready}, 32'd0);
        check32("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check32("rst_mem_in", {24'd0, mem_in}, 32'h00);
        check32("rst_mem_addr", mem_addr, BASE);
        check32("rst_end", {31'd0, streaming_ended}, 32'd0);
        check32("rst_overrun", {31'd0, rx_overrun}, 32'd0);
        check32("rst_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic send_pixel(input logic [7:0] b, input int idx, input bit ack,
                              input bit inject, input int stall);
        int wr0 = wr_seen;
        int tx0 = tx_seen;
        wr_t e;
        e.addr = BASE + 32'(idx);
        e.data = b;
        exp_wr.push_back(e);
        if (ack) exp_tx.push_back(8'hAA);
        stall_left = stall;
        drive_rx(b);
        if (stall > 0) begin
            logic [31:0] a0;
            repeat (5) @(posedge clk);
            #1;
            a0 = mem_addr;
            check32("stall_req_up", {31'd0, mem_req}, 32'd1);
            repeat (10) @(posedge clk);
            #1;
            check32("stall_req_held", {31'd0, mem_req}, 32'd1);
            check32("stall_addr_held", mem_addr, a0);
            check32("stall_addr", mem_addr, e.addr);
            check32("stall_data", {24'd0, mem_in}, {24'd0, b});
            check32("stall_no_ack", {31'd0, tx_ready}, 32'd0);
        end
        wait_wr(wr0 + 1);
        if (inject) begin
            drive_rx(8'h5A);
            check32("overrun_set", {31'd0, rx_overrun}, 32'd1);
        end
        if (ack) wait_tx(tx0 + 1);
    endtask

    task automatic send_frame(input logic [7:0] seed, input int inject_at,
                              input int stall_at, input bit good);
        logic [7:0] cs = 8'h00;
        logic [7:0] b;
        bit ack;
`ifdef IMAGE_STREAM_CHECKSUM_EN
        int tx0;
        if (good) exp_end.push_back(1'b1);
`else
        exp_end.push_back(1'b1);
`endif
        drive_rx(8'hAA);
        check32("sync_busy", {31'd0, busy}, 32'd1);
        check32("sync_overrun_clear", {31'd0, rx_overrun}, 32'd0);
        for (int i = 0; i < TOTAL; i++) begin
            b   = seed + 8'(i);
            cs  = cs ^ b;
            ack = ((i + 1) % WIN == 0) && (i != TOTAL - 1);
`ifndef IMAGE_STREAM_CHECKSUM_EN
            if (i == TOTAL - 1) ack = 1'b1;
`endif
            send_pixel(b, i, ack, (i == inject_at), (i == stall_at) ? 20 : 0);
        end
`ifdef IMAGE_STREAM_CHECKSUM_EN
        tx0 = tx_seen;
        exp_tx.push_back(good ? 8'hAA : 8'h55);
        drive_rx(good ? cs : ~cs);
        wait_tx(tx0 + 1);
`endif
        wait_idle();
        check32("wr_queue_empty", exp_wr.size(), 0);
        check32("tx_queue_empty", exp_tx.size(), 0);
        check32("end_queue_empty", exp_end.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; rx_data = 8'h00; rx_ready = 1'b0;
        tx_busy = 1'b0; mem_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;

        // non-sync byte in IDLE is ignored without raising overrun
        drive_rx(8'h11);
        repeat (3) @(posedge clk);
        #1;
        check32("idle_junk_busy", {31'd0, busy}, 32'd0);
        check32("idle_junk_overrun", {31'd0, rx_overrun}, 32'd0);

        send_frame(8'h00, -1, -1, 1'b1);
        send_frame(8'hA6, -1, 3, 1'b1);
        send_frame(8'h80, 3, -1, 1'b1);
        check32("overrun_sticky", {31'd0, rx_overrun}, 32'd1);

        // partial frame interrupted by reset after three bytes
        drive_rx(8'hAA);
        check32("partial_overrun_clear", {31'd0, rx_overrun}, 32'd0);
        for (int i = 0; i < 3; i++) send_pixel(8'hC0 + 8'(i), i, 1'b0, 1'b0, 0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        reset = 1'b0;

        send_frame(8'h10, -1, -1, 1'b1);
`ifdef IMAGE_STREAM_CHECKSUM_EN
        send_frame(8'h20, -1, -1, 1'b0);
`endif
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
